// File: rtl/uart_link_controller.sv
// uart_link_controller
//   Sequences the two-player UART link between the game FSM and the UART
//   core FIFOs: START handshake, framed score exchange (tag + value),
//   keep-alive resend of the last frame, and lost-peer timeout.
//
//   All outputs are registered. A push or pop is decided from the FIFO
//   flags sampled at a clock edge and is presented for the following cycle.
//   The RX FIFO is first-word fall-through, and its head only advances one
//   cycle after rd_uart. For that reason no new pop is decided while rd_uart
//   is already high.
//
//   Cycle timers are saturating down-counters that are reloaded with
//   PERIOD-1 when they restart. An event fires when a timer's count is zero,
//   so it fires PERIOD edges after the reload.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   enable            link requested by the game FSM (level)
//   my_score          local score, latched when the tag byte is pushed
//   score_valid       1-cycle pulse: my_score changed
//   rx_data/rx_empty  RX FIFO head / empty flag
//   tx_full           TX FIFO full flag
//   rd_uart           RX pop strobe
//   wr_uart/tx_data   TX push strobe and byte
//   uart_start        1-cycle pulse: peer synchronised
//   score_2nd_player  last received peer score
//   score_2nd_valid   1-cycle pulse: score_2nd_player updated
//   link_lost         sticky timeout flag, cleared by the next uart_start
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | link not requested, no FIFO traffic
// SYNC  | resend START every RETRY_CYCLES, wait for the peer's START byte
// RUN   | framed score TX/RX, keep-alive resends, RX silence timeout
module uart_link_controller #(
  parameter logic [7:0] START_BYTE       = 8'hFF,
  parameter logic [7:0] SCORE_TAG        = 8'hA5,
  parameter int         RETRY_CYCLES     = 1_000_000,
  parameter int         KEEPALIVE_CYCLES = 16_000_000,
  parameter int         TIMEOUT_CYCLES   = 65_000_000,
  parameter int         CNT_W            = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] my_score,
  input  logic       score_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_empty,
  input  logic       tx_full,
  output logic       rd_uart,
  output logic       wr_uart,
  output logic [7:0] tx_data,
  output logic       uart_start,
  output logic [7:0] score_2nd_player,
  output logic       score_2nd_valid,
  output logic       link_lost
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SYNC = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [CNT_W-1:0] RETRY_LOAD = CNT_W'(RETRY_CYCLES - 1);
  localparam logic [CNT_W-1:0] KA_LOAD    = CNT_W'(KEEPALIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] retry_cnt, retry_d;
  logic [CNT_W-1:0] ka_cnt, ka_d;
  logic [CNT_W-1:0] to_cnt, to_d;
  logic             pending, pending_d;
  logic             val_due, val_due_d;      // tag pushed, value byte still owed
  logic [7:0]       val_byte, val_byte_d;
  logic             expect_val, expect_val_d;

  logic       wr_d, rd_d, start_d, peer_valid_d, lost_d;
  logic [7:0] tx_data_d, peer_d;

  logic timeout, pop, sync_hit;

  assign timeout  = (state == S_RUN) && (to_cnt == '0);
  assign pop      = enable && (state != S_IDLE) && !rx_empty && !rd_uart && !timeout;
  assign sync_hit = (state == S_SYNC) && pop && (rx_data == START_BYTE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; enable=0 wins over timeout and START reception
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (enable) state_next = S_SYNC;
      S_SYNC: begin
        if (!enable)       state_next = S_IDLE;
        else if (sync_hit) state_next = S_RUN;
      end
      S_RUN: begin
        if (!enable)      state_next = S_IDLE;
        else if (timeout) state_next = S_SYNC;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    wr_d         = 1'b0;
    tx_data_d    = tx_data;
    rd_d         = pop;
    start_d      = 1'b0;
    peer_d       = score_2nd_player;
    peer_valid_d = 1'b0;
    lost_d       = link_lost;
    pending_d    = pending;
    val_due_d    = val_due;
    val_byte_d   = val_byte;
    expect_val_d = expect_val;
    retry_d      = (retry_cnt == '0) ? '0 : retry_cnt - CNT_ONE;
    ka_d         = (ka_cnt == '0)    ? '0 : ka_cnt - CNT_ONE;
    to_d         = (to_cnt == '0)    ? '0 : to_cnt - CNT_ONE;

    if (!enable || state == S_IDLE) begin
      pending_d    = 1'b0;
      val_due_d    = 1'b0;
      expect_val_d = 1'b0;
      retry_d      = '0;               // SYNC entry sends START at once
    end else if (state == S_SYNC) begin
      if (retry_cnt == '0 && !tx_full) begin
        wr_d      = 1'b1;
        tx_data_d = START_BYTE;
        retry_d   = RETRY_LOAD;
      end
      if (sync_hit) begin
        start_d   = 1'b1;
        lost_d    = 1'b0;
        pending_d = 1'b1;              // initial frame on RUN entry
        to_d      = TO_LOAD;
      end
    end else if (timeout) begin
      lost_d       = 1'b1;
      pending_d    = 1'b0;
      val_due_d    = 1'b0;
      expect_val_d = 1'b0;
      retry_d      = '0;
    end else begin
      pending_d = pending | score_valid;
      if (val_due) begin
        if (!tx_full) begin
          wr_d      = 1'b1;
          tx_data_d = val_byte;
          val_due_d = 1'b0;
        end
      end else if ((pending || ka_cnt == '0) && !tx_full) begin
        // a score_valid in this same cycle is covered by this frame
        wr_d       = 1'b1;
        tx_data_d  = SCORE_TAG;
        val_byte_d = my_score;
        val_due_d  = 1'b1;
        pending_d  = 1'b0;
      end
      if (pop) begin
        to_d = TO_LOAD;
        if (expect_val) begin
          peer_d       = rx_data;
          peer_valid_d = 1'b1;
          expect_val_d = 1'b0;
        end else if (rx_data == SCORE_TAG) begin
          expect_val_d = 1'b1;
        end
      end
    end

    if (wr_d) ka_d = KA_LOAD;
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_uart          <= 1'b0;
      tx_data          <= 8'h00;
      rd_uart          <= 1'b0;
      uart_start       <= 1'b0;
      score_2nd_player <= 8'h00;
      score_2nd_valid  <= 1'b0;
      link_lost        <= 1'b0;
      pending          <= 1'b0;
      val_due          <= 1'b0;
      val_byte         <= 8'h00;
      expect_val       <= 1'b0;
      retry_cnt        <= '0;
      ka_cnt           <= '0;
      to_cnt           <= '0;
    end else begin
      wr_uart          <= wr_d;
      tx_data          <= tx_data_d;
      rd_uart          <= rd_d;
      uart_start       <= start_d;
      score_2nd_player <= peer_d;
      score_2nd_valid  <= peer_valid_d;
      link_lost        <= lost_d;
      pending          <= pending_d;
      val_due          <= val_due_d;
      val_byte         <= val_byte_d;
      expect_val       <= expect_val_d;
      retry_cnt        <= retry_d;
      ka_cnt           <= ka_d;
      to_cnt           <= to_d;
    end
  end

endmodule
